// File: rtl/cap_frame_ctrl.sv
// rtl/cap_frame_ctrl.sv - vsync-aligned frame capture sequencer with geometry check
// Pops capture opcodes, gates img_en per frame and reports done/error/timeout status.
module cap_frame_ctrl #(
    parameter int DW_CMD  = 8,
    parameter int IW      = 640,
    parameter int IH      = 512,
    parameter int TIMEOUT = 2000000,
    parameter int CNT_W   = 16
) (
    input  logic              cap_clk,
    input  logic              reset,
    input  logic              cap_vsync,
    input  logic              cap_dvalid,
    input  logic              cmd_rdy,
    input  logic [DW_CMD-1:0] cmd_rdat,
    output logic              cmd_rdreq,
    output logic              img_en,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic              arm_timeout,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        bad_cmd_cnt
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] IW_C     = CNT_W'(IW);
    localparam logic [CNT_W-1:0] IH_C     = CNT_W'(IH);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RDCMD, S_DECODE, S_ARM, S_CAP, S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic               cont, cont_nxt;
    logic               vs_d, dv_d;
    logic [DW_CMD-1:0]  cmd_q;
    logic [WD_W-1:0]    wdog;
    logic [CNT_W-1:0]   pix, line;
    logic               geom_bad, sat;
    logic               wdog_clr, cap_clr, bad_inc;
    logic               fall, rise, line_end;

    assign fall     = vs_d & ~cap_vsync;
    assign rise     = ~vs_d & cap_vsync;
    assign line_end = dv_d & ~cap_dvalid;
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_nxt   = state;
        cont_nxt    = cont;
        cmd_rdreq   = 1'b0;
        arm_timeout = 1'b0;
        frame_done  = 1'b0;
        frame_err   = 1'b0;
        wdog_clr    = 1'b0;
        cap_clr     = 1'b0;
        bad_inc     = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_rdy) begin
                    cmd_rdreq = 1'b1;
                    state_nxt = S_RDCMD;
                end
            end
            S_RDCMD: state_nxt = S_DECODE;
            S_DECODE: begin
                case (cmd_q[7:0])
                    8'h01: begin cont_nxt = 1'b0; wdog_clr = 1'b1; state_nxt = S_ARM; end
                    8'h02: begin cont_nxt = 1'b1; wdog_clr = 1'b1; state_nxt = S_ARM; end
                    8'h03: begin cont_nxt = 1'b0; state_nxt = S_IDLE; end
                    default: begin bad_inc = 1'b1; state_nxt = S_IDLE; end
                endcase
            end
            S_ARM: begin
                // frame start wins over a waiting command and over the watchdog
                if (fall) begin
                    cap_clr   = 1'b1;
                    state_nxt = S_CAP;
                end else if (cmd_rdy) begin
                    cmd_rdreq = 1'b1;
                    state_nxt = S_RDCMD;
                end else if (wdog == WD_LAST) begin
                    arm_timeout = 1'b1;
                    cont_nxt    = 1'b0;
                    state_nxt   = S_IDLE;
                end
            end
            S_CAP: begin
                if (rise) state_nxt = S_DONE;
            end
            S_DONE: begin
                frame_done = 1'b1;
                frame_err  = geom_bad | sat | (line != IH_C);
                if (cont && !cmd_rdy) begin
                    wdog_clr  = 1'b1;
                    state_nxt = S_ARM;
                end else if (cmd_rdy) begin
                    cmd_rdreq = 1'b1;
                    state_nxt = S_RDCMD;
                end else begin
                    cont_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (reset) begin
            cmd_rdreq   = 1'b0;
            arm_timeout = 1'b0;
            frame_done  = 1'b0;
            frame_err   = 1'b0;
        end
    end

    always_ff @(posedge cap_clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cont        <= 1'b0;
            vs_d        <= 1'b1;
            dv_d        <= 1'b0;
            img_en      <= 1'b0;
            cmd_q       <= '0;
            wdog        <= '0;
            pix         <= '0;
            line        <= '0;
            geom_bad    <= 1'b0;
            sat         <= 1'b0;
            frame_cnt   <= '0;
            bad_cmd_cnt <= '0;
        end else begin
            state  <= state_nxt;
            cont   <= cont_nxt;
            vs_d   <= cap_vsync;
            dv_d   <= cap_dvalid;
            img_en <= (state_nxt == S_CAP);
            if (state == S_RDCMD) cmd_q <= cmd_rdat;
            if (wdog_clr) wdog <= '0;
            else if (state == S_ARM) wdog <= wdog + 1'b1;
            if (bad_inc && bad_cmd_cnt != 8'hFF) bad_cmd_cnt <= bad_cmd_cnt + 1'b1;
            // geometry counters saturate and leave a sticky flag that fails the frame
            if (cap_clr) begin
                pix      <= '0;
                line     <= '0;
                geom_bad <= 1'b0;
                sat      <= 1'b0;
            end else if (state == S_CAP) begin
                if (line_end) begin
                    if (pix != IW_C) geom_bad <= 1'b1;
                    pix <= '0;
                    if (line == CNT_MAX) sat <= 1'b1;
                    else line <= line + 1'b1;
                end else if (cap_dvalid) begin
                    if (pix == CNT_MAX) sat <= 1'b1;
                    else pix <= pix + 1'b1;
                end
            end
            if (state == S_DONE) begin
                frame_cnt <= frame_cnt + 1'b1;
                geom_bad  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cap_frame_ctrl.sv
// tb/tb_cap_frame_ctrl.sv - randomized self-checking bench for cap_frame_ctrl
module tb_cap_frame_ctrl;

    localparam int IW = 8;
    localparam int IH = 4;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic reset, cap_vsync, cap_dvalid, cmd_rdy;
    logic [7:0] cmd_rdat;
    logic cmd_rdreq, img_en, busy, frame_done, frame_err, arm_timeout;
    logic [15:0] frame_cnt;
    logic [7:0] bad_cmd_cnt;

    cap_frame_ctrl #(.DW_CMD(8), .IW(IW), .IH(IH), .TIMEOUT(TMO), .CNT_W(16)) dut (
        .cap_clk(clk), .reset(reset), .cap_vsync(cap_vsync), .cap_dvalid(cap_dvalid),
        .cmd_rdy(cmd_rdy), .cmd_rdat(cmd_rdat), .cmd_rdreq(cmd_rdreq), .img_en(img_en),
        .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
        .arm_timeout(arm_timeout), .frame_cnt(frame_cnt), .bad_cmd_cnt(bad_cmd_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    byte unsigned fifo[$];
    int frame_lines[$];
    int cyc = 0;
    int m_rdreq, m_done, m_err, m_tmo, m_img, m_img_first, m_img_last, m_tmo_cyc;
    int m_viol = 0;
    int last_rdreq_cyc, fall_cyc, rise_cyc;
    logic prev_rdreq = 1'b0;
    logic prev_vs = 1'b1;

    task automatic clear_mon();
        m_rdreq = 0; m_done = 0; m_err = 0; m_tmo = 0; m_img = 0;
        m_img_first = -1; m_img_last = -1; m_tmo_cyc = -1;
    endtask

    // one clock: apply inputs, sample just after, then serve the FIFO pop
    task automatic step(input logic vs, input logic dv);
        cap_vsync = vs;
        cap_dvalid = dv;
        cmd_rdy = (fifo.size() > 0);
        #1;
        if (!vs && prev_vs) fall_cyc = cyc;
        if (vs && !prev_vs) rise_cyc = cyc;
        prev_vs = vs;
        if (cmd_rdreq) begin
            m_rdreq++;
            last_rdreq_cyc = cyc;
            if (!cmd_rdy || prev_rdreq) m_viol++;
        end
        prev_rdreq = cmd_rdreq;
        if (img_en) begin
            if (m_img == 0) m_img_first = cyc;
            m_img++;
            m_img_last = cyc;
        end
        if (frame_done) begin
            m_done++;
            if (frame_err) m_err++;
        end
        if (arm_timeout) begin
            m_tmo++;
            m_tmo_cyc = cyc;
        end
        @(posedge clk);
        if (prev_rdreq && fifo.size() > 0) cmd_rdat = fifo.pop_front();
        @(negedge clk);
        cyc++;
    endtask

    function automatic bit model_err();
        bit e;
        e = (frame_lines.size() != IH);
        foreach (frame_lines[i]) if (frame_lines[i] != IW) e = 1'b1;
        return e;
    endfunction

    // kind: 0 good, 1 short line, 2 long line, 3 one line missing, 4 one extra line
    task automatic fill_frame(input int kind);
        int nl;
        frame_lines.delete();
        nl = IH + ((kind == 3) ? -1 : (kind == 4) ? 1 : 0);
        for (int i = 0; i < nl; i++) frame_lines.push_back(IW);
        if (kind == 1) frame_lines[$urandom_range(0, nl - 1)] = IW - 1;
        if (kind == 2) frame_lines[$urandom_range(0, nl - 1)] = IW + 1;
    endtask

    task automatic send_frame(input int push_line, input byte unsigned push_val);
        repeat (10 + $urandom_range(0, 4)) step(1'b1, 1'b0);
        repeat ($urandom_range(1, 3)) step(1'b0, 1'b0);
        foreach (frame_lines[i]) begin
            if (i == push_line) fifo.push_back(push_val);
            repeat (frame_lines[i]) step(1'b0, 1'b1);
            repeat ($urandom_range(1, 3)) step(1'b0, 1'b0);
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        n_checks++; if ({img_en, busy, frame_done, frame_err, arm_timeout, cmd_rdreq} !== 6'b0) begin n_err++; $display("FAIL reset_flags: got %b expected 000000", {img_en, busy, frame_done, frame_err, arm_timeout, cmd_rdreq}); end
        n_checks++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        n_checks++; if (bad_cmd_cnt !== 8'd0) begin n_err++; $display("FAIL reset_bad_cnt: got %0d expected 0", bad_cmd_cnt); end
    endtask

    task automatic test_single();
        clear_mon();
        fifo.push_back(8'h01);
        fill_frame(0);
        send_frame(-1, 8'h00);
        repeat (3) step(1'b1, 1'b0);
        n_checks++; if (m_rdreq != 1) begin n_err++; $display("FAIL single_rdreq: got %0d expected 1", m_rdreq); end
        n_checks++; if (m_img_first != fall_cyc + 1) begin n_err++; $display("FAIL single_img_first: got %0d expected %0d", m_img_first, fall_cyc + 1); end
        n_checks++; if (m_img_last != rise_cyc || m_img != rise_cyc - fall_cyc) begin n_err++; $display("FAIL single_img_span: got last %0d n %0d expected last %0d n %0d", m_img_last, m_img, rise_cyc, rise_cyc - fall_cyc); end
        n_checks++; if (m_done != 1 || m_err != 0) begin n_err++; $display("FAIL single_done: got done %0d err %0d expected 1 0", m_done, m_err); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL single_frame_cnt: got %0d expected 1", frame_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_cont();
        int fc0, exp_img, img3;
        clear_mon();
        fc0 = frame_cnt;
        exp_img = 0;
        fifo.push_back(8'h02);
        for (int f = 0; f < 3; f++) begin
            fill_frame(0);
            send_frame((f == 2) ? 1 : -1, 8'h03);
            exp_img += rise_cyc - fall_cyc;
        end
        repeat (4) step(1'b1, 1'b0);
        n_checks++; if (int'(frame_cnt) != fc0 + 3) begin n_err++; $display("FAIL cont_frame_cnt: got %0d expected %0d", frame_cnt, fc0 + 3); end
        n_checks++; if (m_done != 3 || m_err != 0) begin n_err++; $display("FAIL cont_done: got done %0d err %0d expected 3 0", m_done, m_err); end
        n_checks++; if (m_rdreq != 2) begin n_err++; $display("FAIL cont_rdreq: got %0d expected 2", m_rdreq); end
        n_checks++; if (m_img != exp_img) begin n_err++; $display("FAIL cont_img_cycles: got %0d expected %0d", m_img, exp_img); end
        n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL cont_idle: got busy %b expected 0", busy); end
        img3 = m_img;
        fill_frame(0);
        send_frame(-1, 8'h00);
        n_checks++; if (m_img != img3 || m_done != 3) begin n_err++; $display("FAIL cont_no_4th: got img %0d done %0d expected %0d 3", m_img, m_done, img3); end
    endtask

    task automatic test_geometry();
        int kind, fc0;
        bit exp_e;
        for (int it = 0; it < 8; it++) begin
            kind = (it == 0) ? 1 : (it == 1) ? 3 : int'($urandom_range(0, 4));
            clear_mon();
            fc0 = frame_cnt;
            fifo.push_back(8'h01);
            fill_frame(kind);
            exp_e = model_err();
            send_frame(-1, 8'h00);
            repeat (2) step(1'b1, 1'b0);
            n_checks++; if (m_done != 1 || m_err != int'(exp_e)) begin n_err++; $display("FAIL geom_kind%0d: got done %0d err %0d expected 1 %0d", kind, m_done, m_err, exp_e); end
            n_checks++; if (int'(frame_cnt) != fc0 + 1) begin n_err++; $display("FAIL geom_frame_cnt: got %0d expected %0d", frame_cnt, fc0 + 1); end
        end
    endtask

    task automatic test_timeout();
        int fc0;
        clear_mon();
        fc0 = frame_cnt;
        fifo.push_back(8'h01);
        for (int i = 0; i < 200 && m_tmo == 0; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n_checks++; if (m_tmo != 1 || m_tmo_cyc != last_rdreq_cyc + 3 + TMO - 1) begin n_err++; $display("FAIL timeout_pulse: got n %0d at %0d expected 1 at %0d", m_tmo, m_tmo_cyc, last_rdreq_cyc + 3 + TMO - 1); end
        n_checks++; if (m_img != 0 || int'(frame_cnt) != fc0) begin n_err++; $display("FAIL timeout_no_capture: got img %0d fc %0d expected 0 %0d", m_img, frame_cnt, fc0); end
        n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL timeout_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_bad_cmd();
        int fc0;
        clear_mon();
        fc0 = frame_cnt;
        fifo.push_back(8'h7F);
        fifo.push_back(8'h01);
        fill_frame(0);
        send_frame(-1, 8'h00);
        repeat (2) step(1'b1, 1'b0);
        n_checks++; if (bad_cmd_cnt !== 8'd1) begin n_err++; $display("FAIL bad_cmd_cnt: got %0d expected 1", bad_cmd_cnt); end
        n_checks++; if (m_rdreq != 2 || m_done != 1 || m_err != 0) begin n_err++; $display("FAIL bad_cmd_then_single: got rdreq %0d done %0d err %0d expected 2 1 0", m_rdreq, m_done, m_err); end
        n_checks++; if (int'(frame_cnt) != fc0 + 1) begin n_err++; $display("FAIL bad_cmd_frame_cnt: got %0d expected %0d", frame_cnt, fc0 + 1); end
    endtask

    task automatic test_bad_saturate();
        int v;
        for (int i = 0; i < 260; i++) begin
            v = $urandom_range(4, 256);
            fifo.push_back(byte'(v));
        end
        for (int i = 0; i < 2000 && fifo.size() > 0; i++) step(1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b0);
        n_checks++; if (bad_cmd_cnt !== 8'hFF) begin n_err++; $display("FAIL bad_cmd_saturate: got %0d expected 255", bad_cmd_cnt); end
    endtask

    task automatic test_reset_mid_cap();
        clear_mon();
        fifo.push_back(8'h01);
        repeat (12) step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        for (int l = 0; l < 2; l++) begin
            repeat (IW) step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
        repeat (3) step(1'b0, 1'b1);
        n_checks++; if (img_en !== 1'b1 || frame_cnt == 16'd0) begin n_err++; $display("FAIL midcap_running: got img_en %b fc %0d expected 1 nonzero", img_en, frame_cnt); end
        reset = 1'b1;
        step(1'b0, 1'b1);
        reset = 1'b0;
        n_checks++; if (img_en !== 1'b0) begin n_err++; $display("FAIL midcap_img_drop: got %b expected 0", img_en); end
        clear_mon();
        repeat (IW - 4) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        repeat (IW) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0);
        n_checks++; if (m_done != 0 || m_img != 0) begin n_err++; $display("FAIL midcap_no_done: got done %0d img %0d expected 0 0", m_done, m_img); end
        n_checks++; if (frame_cnt !== 16'd0 || bad_cmd_cnt !== 8'd0) begin n_err++; $display("FAIL midcap_counters: got fc %0d bad %0d expected 0 0", frame_cnt, bad_cmd_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL midcap_idle: got busy %b expected 0", busy); end
    endtask

    initial begin
        reset = 1'b1;
        cap_vsync = 1'b1;
        cap_dvalid = 1'b0;
        cmd_rdy = 1'b0;
        cmd_rdat = 8'h00;
        clear_mon();
        @(negedge clk);
        repeat (2) step(1'b1, 1'b0);
        reset = 1'b0;
        test_reset();
        test_single();
        test_cont();
        test_geometry();
        test_timeout();
        test_bad_cmd();
        test_bad_saturate();
        test_reset_mid_cap();
        n_checks++; if (m_viol != 0) begin n_err++; $display("FAIL rdreq_protocol: got %0d violations expected 0", m_viol); end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
